// File: rtl/regfile_pkg.sv
// Shared widths and the writeback entry layout for the regfile write-port arbiter.
package regfile_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned ENTRY_W = AW + XLEN;

    localparam logic [AW-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO for one writeback requester; exposes per-entry rd/valid
// taps so the top level can detect pending writes to a read address.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH-1:0][AW-1:0]   rd_tap,
    output logic [DEPTH-1:0]           vld_tap
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW:0]                 r_wptr;
    logic [PW:0]                 r_rptr;
    logic [PW:0]                 w_count;
    logic                        w_push;
    logic                        w_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign empty   = (r_wptr == r_rptr);
    assign full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign dout    = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PW-1:0]] <= din;
                r_wptr                <= r_wptr + (PW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (PW+1)'(1);
            end
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_tap
        logic [PW-1:0] w_off;
        assign w_off      = PW'(i) - r_rptr[PW-1:0];
        assign vld_tap[i] = ({1'b0, w_off} < w_count);
        assign rd_tap[i]  = r_mem[i][WIDTH-1 -: AW];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the ALU (A) and
// load (B) writeback paths, with pending-write hazard flags for rs1/rs2.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            pend1,
    output logic            pend2,
    output logic            regwrite,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] writedata
);

    wb_entry_t              w_a_din, w_b_din, w_a_head, w_b_head;
    logic                   w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic                   w_a_push, w_b_push, w_a_pop, w_b_pop;
    logic                   w_contest, w_grant_b;
    logic [DEPTH-1:0][AW-1:0] w_a_rd, w_b_rd;
    logic [DEPTH-1:0]       w_a_vld, w_b_vld;
    logic                   w_hit1, w_hit2;

    logic                   r_rr_b;
    logic                   r_regwrite;
    logic [AW-1:0]          r_rd;
    logic [XLEN-1:0]        r_writedata;

    assign w_a_din = '{rd: a_rd, data: a_data};
    assign w_b_din = '{rd: b_rd, data: b_data};

    // Writes to x0 complete the handshake but are dropped here.
    assign w_a_push = a_valid && !w_a_full && (a_rd != REG_X0);
    assign w_b_push = b_valid && !w_b_full && (b_rd != REG_X0);

    assign w_contest = !w_a_empty && !w_b_empty;
    assign w_grant_b = w_contest ? r_rr_b : !w_b_empty;
    assign w_a_pop   = !w_a_empty && !w_grant_b;
    assign w_b_pop   = !w_b_empty && w_grant_b;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_a_push),
        .din     (w_a_din),
        .pop     (w_a_pop),
        .dout    (w_a_head),
        .full    (w_a_full),
        .empty   (w_a_empty),
        .rd_tap  (w_a_rd),
        .vld_tap (w_a_vld)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_b_push),
        .din     (w_b_din),
        .pop     (w_b_pop),
        .dout    (w_b_head),
        .full    (w_b_full),
        .empty   (w_b_empty),
        .rd_tap  (w_b_rd),
        .vld_tap (w_b_vld)
    );

    // Priority flips only after a contested grant; rd/writedata hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_b      <= 1'b0;
            r_regwrite  <= 1'b0;
            r_rd        <= '0;
            r_writedata <= '0;
        end else begin
            if (w_contest) begin
                r_rr_b <= !w_grant_b;
            end
            if (w_a_pop) begin
                r_regwrite  <= 1'b1;
                r_rd        <= w_a_head.rd;
                r_writedata <= w_a_head.data;
            end else if (w_b_pop) begin
                r_regwrite  <= 1'b1;
                r_rd        <= w_b_head.rd;
                r_writedata <= w_b_head.data;
            end else begin
                r_regwrite  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_hit1 = r_regwrite && (r_rd == rs1);
        w_hit2 = r_regwrite && (r_rd == rs2);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((w_a_vld[i] && (w_a_rd[i] == rs1)) || (w_b_vld[i] && (w_b_rd[i] == rs1))) begin
                w_hit1 = 1'b1;
            end
            if ((w_a_vld[i] && (w_a_rd[i] == rs2)) || (w_b_vld[i] && (w_b_rd[i] == rs2))) begin
                w_hit2 = 1'b1;
            end
        end
    end

    assign pend1     = (rs1 != REG_X0) && w_hit1;
    assign pend2     = (rs2 != REG_X0) && w_hit2;
    assign a_ready   = !w_a_full;
    assign b_ready   = !w_b_full;
    assign regwrite  = r_regwrite;
    assign rd        = r_rd;
    assign writedata = r_writedata;

endmodule
